fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'd0, meaning the PC loaded at reset and on start.
REQ-002 The block SHALL have parameter HALT_INSTR, default 32'hD4400000, meaning the instruction word that stops fetching.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a pulse that begins fetching from RESET_PC.
REQ-006 The block SHALL have port bus_pc, output, 64 bits: the address driven to instruction memory.
REQ-007 The block SHALL have port bus_instruccion, input, 32 bits: the combinational instruction read at bus_pc.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: redirect request from the execute stage.
REQ-009 The block SHALL have port branch_target, input, 64 bits: the redirect address.
REQ-010 The block SHALL have port instr_out, output, 32 bits: the registered instruction delivered to decode.
REQ-011 The block SHALL have port pc_out, output, 64 bits: the PC of instr_out.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr_out/pc_out are valid.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: decode accepts instr_out this cycle.
REQ-014 The block SHALL have port halted, output, 1 bit: the block is in state HALTED.
REQ-015 The block SHALL have port align_err, output, 1 bit: sticky flag set by a misaligned branch target.
REQ-016 The block SHALL have port fetch_count, output, 32 bits: the number of instructions captured since start.

Function
REQ-017 The block SHALL implement the states IDLE, FETCH and HALTED; bus_pc SHALL equal the internal pc_reg combinationally in every state.
REQ-018 In IDLE, a start pulse SHALL cause pc_reg <= RESET_PC, fetch_count <= 0, align_err <= 0 and a transition to FETCH; all other inputs SHALL be ignored.
REQ-019 In FETCH with branch_taken=0 and (instr_valid=0 or instr_ready=1), the block SHALL capture: instr_out <= bus_instruccion, pc_out <= pc_reg, instr_valid <= 1, pc_reg <= pc_reg+4, fetch_count <= fetch_count+1; latency from address to instr_valid SHALL be 1 cycle.
REQ-020 In FETCH with instr_valid=1 and instr_ready=0 (stall), instr_out, pc_out, pc_reg and fetch_count SHALL hold.
REQ-021 In FETCH, branch_taken=1 SHALL have priority over capture and stall: pc_reg <= branch_target, instr_valid <= 0, and no capture that cycle.
REQ-022 If branch_taken=1 and branch_target[1:0]!=0, the block SHALL set align_err <= 1, set instr_valid <= 0, leave pc_reg unchanged and enter HALTED.
REQ-023 A captured word equal to HALT_INSTR SHALL be delivered normally (instr_valid=1), and the state SHALL become HALTED on that same edge with pc_reg not incremented.
REQ-024 In HALTED, an instruction already valid SHALL remain valid until instr_ready=1 and then clear; nothing new SHALL be captured; start SHALL behave as in REQ-018, clearing instr_valid.
REQ-025 pc_reg+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0); fetch_count SHALL wrap modulo 2^32.
REQ-026 The block SHALL ignore start while in FETCH.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, pc_reg=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, align_err=0 and fetch_count=0.
REQ-028 When reset is asserted mid-stall or mid-branch, the block SHALL discard the pending instruction and return to IDLE.

Structure
REQ-029 The state encoding, the PC increment constant (4) and the default HALT_INSTR SHALL reside in a shared package (procesador_pkg).
REQ-030 The block SHALL be a single module; the instruction memory SHALL be instantiated beside it, not inside it.

Verification
REQ-031 Reset, start, IM contents {0:A, 4:B, 8:C}, instr_ready=1 -> pc_out 0,4,8 with instr_out A,B,C on consecutive cycles; fetch_count=3.
REQ-032 instr_ready=0 for 3 cycles while instr_out=B -> instr_out, pc_out and bus_pc held at B/4/8; resume without loss or duplication.
REQ-033 branch_taken with target 64'h40 during a stall -> the next valid has pc_out=0x40; the stalled instruction is dropped.
REQ-034 branch_target 64'h42 -> align_err=1, halted=1, instr_valid=0; a following start clears align_err and refetches from 0.
REQ-035 HALT_INSTR at address 12 -> delivered with pc_out=12, halted=1, bus_pc stays 12, no further captures.
REQ-036 pc_reg=64'hFFFF_FFFF_FFFF_FFFC -> next bus_pc=0; rst_n pulsed asynchronously mid-cycle -> outputs zero immediately.

Source files
------------

// File: rtl/procesador_pkg.sv
// Shared definitions for the processor front end: fetch FSM encoding,
// PC step and the default halt opcode.
package procesador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [63:0] PC_INCR            = 64'd4;
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hD440_0000;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch: drives bus_pc, registers the returned word for decode (1-cycle latency).
// Backpressure: instr_valid && !instr_ready holds instr_out/pc_out/pc_reg; a branch overrides the stall.
module fetch_controller
  import procesador_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [63:0] bus_pc,
  input  logic [31:0] bus_instruccion,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [31:0] instr_out,
  output logic [63:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        align_err,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_nxt;
  logic [63:0]  pc_reg, pc_nxt;
  logic [31:0]  instr_nxt;
  logic [63:0]  pc_out_nxt;
  logic         valid_nxt;
  logic         align_nxt;
  logic [31:0]  count_nxt;

  assign bus_pc = pc_reg;
  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc_reg      <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc_reg      <= pc_nxt;
      instr_out   <= instr_nxt;
      pc_out      <= pc_out_nxt;
      instr_valid <= valid_nxt;
      align_err   <= align_nxt;
      fetch_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_reg;
    instr_nxt  = instr_out;
    pc_out_nxt = pc_out;
    valid_nxt  = instr_valid;
    align_nxt  = align_err;
    count_nxt  = fetch_count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = RESET_PC;
          count_nxt = '0;
          align_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        if (branch_taken) begin
          // Redirect drops whatever is sitting in the output register.
          valid_nxt = 1'b0;
          if (branch_target[1:0] != 2'b00) begin
            align_nxt = 1'b1;
            state_nxt = ST_HALTED;
          end else begin
            pc_nxt = branch_target;
          end
        end else if (!instr_valid || instr_ready) begin
          instr_nxt  = bus_instruccion;
          pc_out_nxt = pc_reg;
          valid_nxt  = 1'b1;
          count_nxt  = fetch_count + 32'd1;
          // The halt word is still handed to decode; the PC parks on it.
          if (bus_instruccion == HALT_INSTR) begin
            state_nxt = ST_HALTED;
          end else begin
            pc_nxt = pc_reg + PC_INCR;
          end
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = RESET_PC;
          count_nxt = '0;
          align_nxt = 1'b0;
          valid_nxt = 1'b0;
        end else if (instr_valid && instr_ready) begin
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, async reset sequences,
// then randomized traffic against a behavioural model.
module tb_fetch_controller;

  localparam logic [31:0] HALT = 32'hD440_0000;
  localparam logic [31:0] WA = 32'hA000_0000;
  localparam logic [31:0] WB = 32'hB000_0004;
  localparam logic [31:0] WC = 32'hC000_0008;
  localparam logic [31:0] WD = 32'hD000_0040;
  localparam logic [31:0] WE = 32'hE000_0FFC;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] bus_pc;
  logic [31:0] bus_instruccion;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        align_err;
  logic [31:0] fetch_count;

  logic [31:0] imem [0:255];
  assign bus_instruccion = imem[bus_pc[9:2]];

  fetch_controller #(.RESET_PC(64'd0), .HALT_INSTR(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus_pc(bus_pc),
    .bus_instruccion(bus_instruccion), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted),
    .align_err(align_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [63:0] epc,
                            input logic [31:0] ein, input logic [63:0] ebus,
                            input logic eh, input logic ea, input logic [31:0] ecnt);
    check({tag, ".instr_valid"}, 64'(instr_valid), 64'(ev));
    check({tag, ".bus_pc"},      bus_pc,           ebus);
    check({tag, ".halted"},      64'(halted),      64'(eh));
    check({tag, ".align_err"},   64'(align_err),   64'(ea));
    check({tag, ".fetch_count"}, 64'(fetch_count), 64'(ecnt));
    if (ev) begin
      check({tag, ".pc_out"},    pc_out,           epc);
      check({tag, ".instr_out"}, 64'(instr_out),   64'(ein));
    end
  endtask

  typedef struct {
    logic        start;
    logic        bt;
    logic [63:0] tgt;
    logic        rdy;
    logic        ev;
    logic [63:0] epc;
    logic [31:0] ein;
    logic [63:0] ebus;
    logic        eh;
    logic        ea;
    logic [31:0] ecnt;
  } vec_t;

  function automatic vec_t mk(logic s, logic b, logic [63:0] t, logic r, logic ev,
                              logic [63:0] epc, logic [31:0] ein, logic [63:0] ebus,
                              logic eh, logic ea, logic [31:0] ecnt);
    vec_t v;
    v.start = s; v.bt = b; v.tgt = t; v.rdy = r; v.ev = ev; v.epc = epc;
    v.ein = ein; v.ebus = ebus; v.eh = eh; v.ea = ea; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl [23];

  // Behavioural model: running/stopped flags plus the architectural values.
  logic        m_running, m_stopped, m_valid, m_align;
  logic [63:0] m_pc, m_pcout;
  logic [31:0] m_instr, m_count;

  task automatic model_reset();
    m_running = 0; m_stopped = 0; m_valid = 0; m_align = 0;
    m_pc = 64'd0; m_pcout = 64'd0; m_instr = 32'd0; m_count = 32'd0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [63:0] t, input logic r);
    logic [31:0] word;
    word = imem[m_pc[9:2]];
    if (!m_running && !m_stopped) begin
      if (s) begin m_running = 1; m_pc = 64'd0; m_count = 0; m_align = 0; end
    end else if (m_stopped) begin
      if (s) begin
        m_running = 1; m_stopped = 0; m_pc = 64'd0; m_count = 0; m_align = 0; m_valid = 0;
      end else if (m_valid && r) m_valid = 0;
    end else if (b) begin
      m_valid = 0;
      if (t % 4 != 0) begin m_align = 1; m_running = 0; m_stopped = 1; end
      else m_pc = t;
    end else if (!m_valid || r) begin
      m_instr = word; m_pcout = m_pc; m_valid = 1; m_count = m_count + 1;
      if (word == HALT) begin m_running = 0; m_stopped = 1; end
      else m_pc = m_pc + 4;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    imem[0] = WA; imem[1] = WB; imem[2] = WC; imem[3] = HALT; imem[16] = WD; imem[255] = WE;

    //            st bt tgt     rdy ev pc_out  instr bus_pc  h  a  cnt
    tbl[0]  = mk(1, 0, 64'h0,  1,  0, 64'h0,  0,    64'h0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 64'h0,  1,  1, 64'h0,  WA,   64'h4,  0, 0, 1);
    tbl[2]  = mk(0, 0, 64'h0,  1,  1, 64'h4,  WB,   64'h8,  0, 0, 2);
    tbl[3]  = mk(0, 0, 64'h0,  0,  1, 64'h4,  WB,   64'h8,  0, 0, 2);
    tbl[4]  = mk(0, 0, 64'h0,  0,  1, 64'h4,  WB,   64'h8,  0, 0, 2);
    tbl[5]  = mk(0, 0, 64'h0,  0,  1, 64'h4,  WB,   64'h8,  0, 0, 2);
    tbl[6]  = mk(0, 0, 64'h0,  1,  1, 64'h8,  WC,   64'hC,  0, 0, 3);
    tbl[7]  = mk(0, 0, 64'h0,  1,  1, 64'hC,  HALT, 64'hC,  1, 0, 4);
    tbl[8]  = mk(0, 0, 64'h0,  0,  1, 64'hC,  HALT, 64'hC,  1, 0, 4);
    tbl[9]  = mk(0, 0, 64'h0,  1,  0, 64'h0,  0,    64'hC,  1, 0, 4);
    tbl[10] = mk(0, 1, 64'h40, 1,  0, 64'h0,  0,    64'hC,  1, 0, 4);
    tbl[11] = mk(1, 0, 64'h0,  1,  0, 64'h0,  0,    64'h0,  0, 0, 0);
    tbl[12] = mk(0, 0, 64'h0,  1,  1, 64'h0,  WA,   64'h4,  0, 0, 1);
    tbl[13] = mk(0, 0, 64'h0,  0,  1, 64'h0,  WA,   64'h4,  0, 0, 1);
    tbl[14] = mk(0, 1, 64'h40, 0,  0, 64'h0,  0,    64'h40, 0, 0, 1);
    tbl[15] = mk(0, 0, 64'h0,  1,  1, 64'h40, WD,   64'h44, 0, 0, 2);
    tbl[16] = mk(0, 1, 64'h42, 1,  0, 64'h0,  0,    64'h44, 1, 1, 2);
    tbl[17] = mk(0, 0, 64'h0,  1,  0, 64'h0,  0,    64'h44, 1, 1, 2);
    tbl[18] = mk(1, 0, 64'h0,  1,  0, 64'h0,  0,    64'h0,  0, 0, 0);
    tbl[19] = mk(1, 0, 64'h0,  1,  1, 64'h0,  WA,   64'h4,  0, 0, 1);
    tbl[20] = mk(0, 1, TOP,    1,  0, 64'h0,  0,    TOP,    0, 0, 1);
    tbl[21] = mk(0, 0, 64'h0,  1,  1, TOP,    WE,   64'h0,  0, 0, 2);
    tbl[22] = mk(0, 0, 64'h0,  0,  1, TOP,    WE,   64'h0,  0, 0, 2);

    rst_n = 1'b0; start = 0; branch_taken = 0; branch_target = '0; instr_ready = 0;
    @(negedge clk); @(negedge clk);
    check_outs("reset", 0, 64'h0, 0, 64'h0, 0, 0, 0);
    check("reset.pc_out", pc_out, 64'h0);
    check("reset.instr_out", 64'(instr_out), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      start = tbl[i].start; branch_taken = tbl[i].bt;
      branch_target = tbl[i].tgt; instr_ready = tbl[i].rdy;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ein,
                 tbl[i].ebus, tbl[i].eh, tbl[i].ea, tbl[i].ecnt);
    end

    // Asynchronous reset in the middle of a stall.
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check_outs("async_stall", 0, 64'h0, 0, 64'h0, 0, 0, 0);
    check("async_stall.pc_out", pc_out, 64'h0);
    check("async_stall.instr_out", 64'(instr_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; start = 1; instr_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk);
    check_outs("prebranch", 1, 64'h4, WB, 64'h8, 0, 0, 2);

    // Reset lands while a redirect is being presented.
    branch_taken = 1; branch_target = 64'h80;
    #2; rst_n = 1'b0; #1;
    check_outs("async_branch", 0, 64'h0, 0, 64'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check_outs("post_reset_idle", 0, 64'h0, 0, 64'h0, 0, 0, 0);
    branch_taken = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++)
      imem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        s, b, r;
      logic [63:0] t;
      s = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       t = TOP;
        1, 2:    t = {54'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default: t = {54'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      start = s; branch_taken = b; branch_target = t; instr_ready = r;
      model_step(s, b, t, r);
      @(negedge clk);
      check_outs($sformatf("rand%0d", cyc), m_valid, m_pcout, m_instr, m_pc,
                 m_stopped, m_align, m_count);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
